// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_pkg
// Description : Shared encodings for the branch resolve unit: branch types,
//               condition codes and the predictor counter reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JAL  = 2'b01,
        BR_JALR = 2'b10,
        BR_NONE = 2'b11
    } br_type_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Weakly not-taken
    localparam logic [1:0] C_CTR_RESET = 2'b01;

    // 010 and 011 are the only undefined conditional encodings
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_if
// Description : Request / result / prediction bundle of the branch resolve
//               unit. master = pipeline side, slave = resolve unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [1:0]      br_type;
    logic            in_pred_taken;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            out_valid;
    logic            taken;
    logic [XLEN-1:0] link_addr;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            misalign_exc;
    logic            illegal_br;

    modport master (
        output in_valid, pc, rs1_val, rs2_val, imm, funct3, br_type,
               in_pred_taken, pred_pc,
        input  in_ready, pred_taken, out_valid, taken, link_addr, redirect,
               redirect_pc, flush, misalign_exc, illegal_br
    );

    modport slave (
        input  in_valid, pc, rs1_val, rs2_val, imm, funct3, br_type,
               in_pred_taken, pred_pc,
        output in_ready, pred_taken, out_valid, taken, link_addr, redirect,
               redirect_pc, flush, misalign_exc, illegal_br
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_bht.sv
`default_nettype none
// ============================================================================
// Module      : bru_bht
// Description : Branch history table of 2-bit saturating counters with one
//               combinational lookup port and one registered update port.
//               Lookup reads the stored value, so a same-cycle update to the
//               same entry is seen only on the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bru_bht
    import branch_resolve_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic [IDXW-1:0] i_lookup_idx,
    output logic                 o_lookup_taken,
    input  wire logic            i_upd_en,
    input  wire logic [IDXW-1:0] i_upd_idx,
    input  wire logic            i_upd_taken
);

    logic [1:0] w_ctr_all [ENTRIES];

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        logic [1:0] r_ctr_q;
        logic [1:0] w_ctr_d;

        // Saturating increment on taken, decrement on not-taken
        always_comb begin
            w_ctr_d = r_ctr_q;
            if (i_upd_en && (i_upd_idx == IDXW'(g))) begin
                if (i_upd_taken) begin
                    if (r_ctr_q != 2'b11) w_ctr_d = r_ctr_q + 2'd1;
                end else begin
                    if (r_ctr_q != 2'b00) w_ctr_d = r_ctr_q - 2'd1;
                end
            end
        end

        // Counter register, reset to weakly not-taken
        always_ff @(posedge clk) begin
            if (rst) r_ctr_q <= C_CTR_RESET;
            else     r_ctr_q <= w_ctr_d;
        end

        assign w_ctr_all[g] = r_ctr_q;
    end

    assign o_lookup_taken = w_ctr_all[i_lookup_idx][1];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves conditional branches, JAL and JALR one cycle after
//               acceptance, detects mispredicts, raises redirect/flush and
//               exception flags. Optional BHT predictor enabled by defining
//               BRU_PREDICTOR_EN; otherwise pred_taken is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    branch_resolve_unit_if.slave  bus
);

    localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic            w_accept;
    logic            w_cmp_taken;
    logic            w_f3_legal;
    logic            w_taken;
    logic            w_ctrl_flow;
    logic            w_illegal;
    logic            w_misalign;
    logic            w_mispredict;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;

    logic            r_out_valid_q,   w_out_valid_d;
    logic            r_taken_q,       w_taken_d;
    logic            r_redirect_q,    w_redirect_d;
    logic            r_misalign_q,    w_misalign_d;
    logic            r_illegal_q,     w_illegal_d;
    logic [XLEN-1:0] r_link_q,        w_link_d;
    logic [XLEN-1:0] r_redirect_pc_q, w_redirect_pc_d;
    logic [FCW-1:0]  r_flush_cnt_q,   w_flush_cnt_d;

    assign bus.in_ready = (r_flush_cnt_q == '0);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_f3_legal   = f3_is_legal(bus.funct3);
    assign w_link       = bus.pc + XLEN'(4);

    // Condition evaluation on the raw operands
    always_comb begin
        w_cmp_taken = 1'b0;
        case (bus.funct3)
            F3_BEQ:  w_cmp_taken = (bus.rs1_val == bus.rs2_val);
            F3_BNE:  w_cmp_taken = (bus.rs1_val != bus.rs2_val);
            F3_BLT:  w_cmp_taken = ($signed(bus.rs1_val) <  $signed(bus.rs2_val));
            F3_BGE:  w_cmp_taken = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
            F3_BLTU: w_cmp_taken = (bus.rs1_val <  bus.rs2_val);
            F3_BGEU: w_cmp_taken = (bus.rs1_val >= bus.rs2_val);
            default: w_cmp_taken = 1'b0;
        endcase
    end

    // Outcome, target and mispredict classification per branch type
    always_comb begin
        w_taken     = 1'b0;
        w_ctrl_flow = 1'b0;
        w_illegal   = 1'b0;
        w_target    = bus.pc + bus.imm;
        case (br_type_e'(bus.br_type))
            BR_COND: begin
                if (w_f3_legal) begin
                    w_taken     = w_cmp_taken;
                    w_ctrl_flow = 1'b1;
                end else begin
                    w_illegal   = 1'b1;
                end
            end
            BR_JAL: begin
                w_taken     = 1'b1;
                w_ctrl_flow = 1'b1;
            end
            BR_JALR: begin
                w_target    = (bus.rs1_val + bus.imm) & ~XLEN'(1);
                w_taken     = 1'b1;
                w_ctrl_flow = 1'b1;
            end
            default: ;
        endcase
        // A misaligned taken target raises an exception instead of redirecting
        w_misalign   = w_taken && w_target[1];
        w_mispredict = w_ctrl_flow && (w_taken != bus.in_pred_taken) && !w_misalign;
    end

    // Next-state for result registers and the flush countdown
    always_comb begin
        w_out_valid_d   = w_accept;
        w_taken_d       = w_accept && w_taken;
        w_redirect_d    = w_accept && w_mispredict;
        w_misalign_d    = w_accept && w_misalign;
        w_illegal_d     = w_accept && w_illegal;
        w_link_d        = r_link_q;
        w_redirect_pc_d = r_redirect_pc_q;
        w_flush_cnt_d   = (r_flush_cnt_q != '0) ? r_flush_cnt_q - FCW'(1) : '0;
        if (w_accept) begin
            w_link_d        = w_link;
            w_redirect_pc_d = w_taken ? w_target : w_link;
            if (w_mispredict) w_flush_cnt_d = FCW'(FLUSH_CYCLES);
        end
    end

    // Result and flush registers; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_q   <= 1'b0;
            r_taken_q       <= 1'b0;
            r_redirect_q    <= 1'b0;
            r_misalign_q    <= 1'b0;
            r_illegal_q     <= 1'b0;
            r_link_q        <= '0;
            r_redirect_pc_q <= '0;
            r_flush_cnt_q   <= '0;
        end else begin
            r_out_valid_q   <= w_out_valid_d;
            r_taken_q       <= w_taken_d;
            r_redirect_q    <= w_redirect_d;
            r_misalign_q    <= w_misalign_d;
            r_illegal_q     <= w_illegal_d;
            r_link_q        <= w_link_d;
            r_redirect_pc_q <= w_redirect_pc_d;
            r_flush_cnt_q   <= w_flush_cnt_d;
        end
    end

    assign bus.out_valid    = r_out_valid_q;
    assign bus.taken        = r_taken_q;
    assign bus.redirect     = r_redirect_q;
    assign bus.misalign_exc = r_misalign_q;
    assign bus.illegal_br   = r_illegal_q;
    assign bus.link_addr    = r_link_q;
    assign bus.redirect_pc  = r_redirect_pc_q;
    assign bus.flush        = (r_flush_cnt_q != '0);

`ifdef BRU_PREDICTOR_EN
    localparam int IDXW = $clog2(BHT_ENTRIES);

    bru_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDXW    (IDXW)
    ) u_bht (
        .clk            (clk),
        .rst            (rst),
        .i_lookup_idx   (bus.pred_pc[IDXW+1:2]),
        .o_lookup_taken (bus.pred_taken),
        .i_upd_en       (w_accept && (br_type_e'(bus.br_type) == BR_COND) && w_f3_legal),
        .i_upd_idx      (bus.pc[IDXW+1:2]),
        .i_upd_taken    (w_cmp_taken)
    );
`else
    logic w_unused_pred_pc;
    assign w_unused_pred_pc = ^bus.pred_pc;
    assign bus.pred_taken   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

`ifdef BRU_PREDICTOR_EN
    localparam logic C_PRED = 1'b1;
`else
    localparam logic C_PRED = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   held;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(
        .XLEN         (32),
        .BHT_ENTRIES  (16),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one request, wait (bounded) while held off, return just after the accepting edge
    task automatic send(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [2:0] f3, input logic [1:0] bt,
                        input logic pred, output int n_held);
        @(negedge clk);
        bus.pc            = pc;
        bus.rs1_val       = rs1;
        bus.rs2_val       = rs2;
        bus.imm           = imm;
        bus.funct3        = f3;
        bus.br_type       = bt;
        bus.in_pred_taken = pred;
        bus.in_valid      = 1'b1;
        n_held = 0;
        while (!bus.in_ready && n_held < 20) begin
            @(negedge clk);
            n_held++;
        end
        if (n_held >= 20) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.pc            = '0;
        bus.rs1_val       = '0;
        bus.rs2_val       = '0;
        bus.imm           = '0;
        bus.funct3        = '0;
        bus.br_type       = 2'b11;
        bus.in_pred_taken = 1'b0;
        bus.pred_pc       = 32'h8;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",    32'(bus.in_ready), 32'd1);
        check("rst_out_valid",   32'(bus.out_valid), 32'd0);
        check("rst_taken",       32'(bus.taken), 32'd0);
        check("rst_redirect",    32'(bus.redirect), 32'd0);
        check("rst_flush",       32'(bus.flush), 32'd0);
        check("rst_misalign",    32'(bus.misalign_exc), 32'd0);
        check("rst_illegal",     32'(bus.illegal_br), 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'h0);
        check("rst_link",        bus.link_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // BEQ equal, predicted not-taken: mispredict with 2-cycle flush
        send(32'h100, 32'd5, 32'd5, 32'h20, 3'b000, 2'b00, 1'b0, held);
        check("beq_valid",       32'(bus.out_valid), 32'd1);
        check("beq_taken",       32'(bus.taken), 32'd1);
        check("beq_redirect",    32'(bus.redirect), 32'd1);
        check("beq_redirect_pc", bus.redirect_pc, 32'h120);
        check("beq_link",        bus.link_addr, 32'h104);
        check("beq_flush1",      32'(bus.flush), 32'd1);
        check("beq_ready1",      32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("beq_valid_drop",  32'(bus.out_valid), 32'd0);
        check("beq_redir_drop",  32'(bus.redirect), 32'd0);
        check("beq_flush2",      32'(bus.flush), 32'd1);
        check("beq_ready2",      32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("beq_flush_end",   32'(bus.flush), 32'd0);
        check("beq_ready_back",  32'(bus.in_ready), 32'd1);

        // BLT signed: -1 < 1 taken, mispredict
        send(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'b100, 2'b00, 1'b0, held);
        check("blt_taken",       32'(bus.taken), 32'd1);
        check("blt_redirect",    32'(bus.redirect), 32'd1);
        check("blt_redirect_pc", bus.redirect_pc, 32'h210);

        // BLTU same operands: not taken, predicted correctly
        send(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'b110, 2'b00, 1'b0, held);
        check("bltu_valid",      32'(bus.out_valid), 32'd1);
        check("bltu_taken",      32'(bus.taken), 32'd0);
        check("bltu_redirect",   32'(bus.redirect), 32'd0);
        check("bltu_flush",      32'(bus.flush), 32'd0);

        // BGEU: 1 >= 0xFFFFFFFF unsigned is false
        send(32'h200, 32'd1, 32'hFFFF_FFFF, 32'h10, 3'b111, 2'b00, 1'b0, held);
        check("bgeu_taken",      32'(bus.taken), 32'd0);
        check("bgeu_redirect",   32'(bus.redirect), 32'd0);

        // JALR to 0x202: misaligned, no redirect
        send(32'h40, 32'h203, 32'd0, 32'h0, 3'b000, 2'b10, 1'b1, held);
        check("jalr_taken",      32'(bus.taken), 32'd1);
        check("jalr_misalign",   32'(bus.misalign_exc), 32'd1);
        check("jalr_redirect",   32'(bus.redirect), 32'd0);
        check("jalr_flush",      32'(bus.flush), 32'd0);
        check("jalr_link",       bus.link_addr, 32'h44);

        // Illegal condition code at pc 0x8: no predictor update
        send(32'h8, 32'd1, 32'd1, 32'h40, 3'b010, 2'b00, 1'b0, held);
        check("ill_illegal",     32'(bus.illegal_br), 32'd1);
        check("ill_taken",       32'(bus.taken), 32'd0);
        check("ill_redirect",    32'(bus.redirect), 32'd0);
        check("ill_pred",        32'(bus.pred_taken), 32'd0);

        // Three taken BNEs at pc 0x8 train the counter 01->10->11->11
        send(32'h8, 32'd1, 32'd2, 32'h40, 3'b001, 2'b00, 1'b1, held);
        check("bne1_taken",      32'(bus.taken), 32'd1);
        check("bne1_redirect",   32'(bus.redirect), 32'd0);
        check("bne1_pred",       32'(bus.pred_taken), 32'(C_PRED));
        send(32'h8, 32'd1, 32'd2, 32'h40, 3'b001, 2'b00, 1'b1, held);
        check("bne2_pred",       32'(bus.pred_taken), 32'(C_PRED));
        send(32'h8, 32'd1, 32'd2, 32'h40, 3'b001, 2'b00, 1'b1, held);
        check("bne3_pred",       32'(bus.pred_taken), 32'(C_PRED));
        // Not-taken BNE: 11->10 still predicts taken; mispredict to pc+4
        send(32'h8, 32'd7, 32'd7, 32'h40, 3'b001, 2'b00, 1'b1, held);
        check("bne4_taken",      32'(bus.taken), 32'd0);
        check("bne4_redirect",   32'(bus.redirect), 32'd1);
        check("bne4_redirect_pc", bus.redirect_pc, 32'hC);
        check("bne4_pred",       32'(bus.pred_taken), 32'(C_PRED));

        // JAL with negative offset, held off by the previous flush
        send(32'h1000, 32'd0, 32'd0, 32'hFFFF_FFF8, 3'b000, 2'b01, 1'b0, held);
        check("jal_taken",       32'(bus.taken), 32'd1);
        check("jal_redirect",    32'(bus.redirect), 32'd1);
        check("jal_redirect_pc", bus.redirect_pc, 32'hFF8);
        check("jal_link",        bus.link_addr, 32'h1004);

        // BGE offered during the JAL flush: held off two cycles, not dropped
        send(32'h300, 32'd3, 32'd3, 32'h8, 3'b101, 2'b00, 1'b1, held);
        check("hold_cycles",     32'(held), 32'd2);
        check("bge_valid",       32'(bus.out_valid), 32'd1);
        check("bge_taken",       32'(bus.taken), 32'd1);
        check("bge_redirect",    32'(bus.redirect), 32'd0);

        // br_type none predicted taken: no redirect
        send(32'h500, 32'd0, 32'd0, 32'h8, 3'b000, 2'b11, 1'b1, held);
        check("none_valid",      32'(bus.out_valid), 32'd1);
        check("none_taken",      32'(bus.taken), 32'd0);
        check("none_redirect",   32'(bus.redirect), 32'd0);
        check("none_flush",      32'(bus.flush), 32'd0);
        @(posedge clk); #1;
        check("none_valid_drop", 32'(bus.out_valid), 32'd0);

        // Reset during an active flush
        @(negedge clk);
        bus.pc = 32'h100; bus.rs1_val = 32'd5; bus.rs2_val = 32'd5; bus.imm = 32'h20;
        bus.funct3 = 3'b000; bus.br_type = 2'b00; bus.in_pred_taken = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("rf_flush_pre",    32'(bus.flush), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rf_out_valid",    32'(bus.out_valid), 32'd0);
        check("rf_redirect",     32'(bus.redirect), 32'd0);
        check("rf_flush",        32'(bus.flush), 32'd0);
        check("rf_ready",        32'(bus.in_ready), 32'd1);

        // Request coincident with reset is discarded
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("rq_out_valid",    32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rq_out_valid2",   32'(bus.out_valid), 32'd0);
        check("rst_pred_ctr",    32'(bus.pred_taken), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
